// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART command deframer: opcodes, command types,
// error causes and FSM states.
package uart_frame_pkg;

    localparam logic [7:0] OP_REG_WR  = 8'hAA;
    localparam logic [7:0] OP_REG_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_REG_WR  = 2'd0,
        CMD_REG_RD  = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ERR_LINE       = 2'd0,
        ERR_BAD_OPCODE = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_OVERRUN    = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_GET_OPA  = 3'd3,
        ST_GET_OPB  = 3'd4,
        ST_GET_FUN  = 3'd5,
        ST_ISSUE    = 3'd6
    } state_e;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: down-counter reloaded on clear, expire at terminal count zero.
// Expire is asserted in the TIMEOUT_CYC-th consecutive enabled cycle after a clear.
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    import uart_frame_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles UART bytes into register/ALU commands and hands them to the
// controller over valid/ready; dropped frames are reported on frame_err/err_code.
//
// state       | meaning
// ST_IDLE     | waiting for an opcode byte
// ST_GET_ADDR | REG_WR/REG_RD: waiting for address byte
// ST_GET_DATA | REG_WR: waiting for write data byte
// ST_GET_OPA  | ALU_OP: waiting for operand A
// ST_GET_OPB  | ALU_OP: waiting for operand B
// ST_GET_FUN  | ALU_OP/ALU_NOP: waiting for function byte
// ST_ISSUE    | command presented, waiting for cmd_ready
module uart_cmd_deframer
    import uart_frame_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              par_err,
    input  logic              stp_err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_wdata,
    output logic [7:0]        cmd_op_a,
    output logic [7:0]        cmd_op_b,
    output logic [FUN_W-1:0]  cmd_fun,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    state_e            state;
    cmd_type_e         kind_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        opa_q;
    logic [7:0]        opb_q;
    logic              in_frame;
    logic              tmr_expire;

    assign in_frame = (state != ST_IDLE) && (state != ST_ISSUE);

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || !in_frame),
        .enable (in_frame),
        .expire (tmr_expire)
    );

    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            kind_q    <= CMD_REG_WR;
            addr_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            cmd_type  <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_op_a  <= '0;
            cmd_op_b  <= '0;
            cmd_fun   <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid) begin
                if (state == ST_ISSUE) begin
                    // Pending command wins; any byte here, clean or not, is an overrun.
                    frame_err <= 1'b1;
                    err_code  <= ERR_OVERRUN;
                    if (cmd_ready) begin
                        state <= ST_IDLE;
                    end
                end else if (par_err || stp_err) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_LINE;
                    state     <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            case (rx_data)
                                OP_REG_WR: begin
                                    kind_q <= CMD_REG_WR;
                                    state  <= ST_GET_ADDR;
                                end
                                OP_REG_RD: begin
                                    kind_q <= CMD_REG_RD;
                                    state  <= ST_GET_ADDR;
                                end
                                OP_ALU_OP: begin
                                    kind_q <= CMD_ALU_OP;
                                    state  <= ST_GET_OPA;
                                end
                                OP_ALU_NOP: begin
                                    kind_q <= CMD_ALU_NOP;
                                    state  <= ST_GET_FUN;
                                end
                                default: begin
                                    frame_err <= 1'b1;
                                    err_code  <= ERR_BAD_OPCODE;
                                end
                            endcase
                        end
                        ST_GET_ADDR: begin
                            if (kind_q == CMD_REG_WR) begin
                                addr_q <= rx_data[ADDR_W-1:0];
                                state  <= ST_GET_DATA;
                            end else begin
                                cmd_type <= kind_q;
                                cmd_addr <= rx_data[ADDR_W-1:0];
                                state    <= ST_ISSUE;
                            end
                        end
                        ST_GET_DATA: begin
                            cmd_type  <= kind_q;
                            cmd_addr  <= addr_q;
                            cmd_wdata <= rx_data;
                            state     <= ST_ISSUE;
                        end
                        ST_GET_OPA: begin
                            opa_q <= rx_data;
                            state <= ST_GET_OPB;
                        end
                        ST_GET_OPB: begin
                            opb_q <= rx_data;
                            state <= ST_GET_FUN;
                        end
                        ST_GET_FUN: begin
                            cmd_type <= kind_q;
                            cmd_fun  <= rx_data[FUN_W-1:0];
                            if (kind_q == CMD_ALU_OP) begin
                                cmd_op_a <= opa_q;
                                cmd_op_b <= opb_q;
                            end
                            state <= ST_ISSUE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (state == ST_ISSUE) begin
                if (cmd_ready) begin
                    state <= ST_IDLE;
                end
            end else if (in_frame && tmr_expire) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_IDLE;
            end
        end
    end

endmodule
